// File: rtl/ram_arbiter_if.sv
// ram_arbiter_if: cache-port and RAM-port signal bundle for the RAM arbiter
interface ram_arbiter_if #(parameter int CPUS = 2, parameter int WORD_W = 32);
  localparam int GW = $clog2(2 * CPUS);
  logic [CPUS-1:0] iREN, dREN, dWEN, iwait, dwait;
  logic [CPUS*WORD_W-1:0] iaddr, daddr, dstore, iload, dload;
  logic ramREN, ramWEN;
  logic [WORD_W-1:0] ramaddr, ramstore, ramload;
  logic [1:0] ramstate;
  logic [GW-1:0] gnt_id;
  logic busy;
  modport slave (
    input iREN, dREN, dWEN, iaddr, daddr, dstore, ramload, ramstate,
    output iwait, dwait, iload, dload, ramREN, ramWEN, ramaddr, ramstore, gnt_id, busy
  );
  modport master (
    output iREN, dREN, dWEN, iaddr, daddr, dstore, ramload, ramstate,
    input iwait, dwait, iload, dload, ramREN, ramWEN, ramaddr, ramstore, gnt_id, busy
  );
endinterface

// File: rtl/ram_arbiter.sv
// ram_arbiter: round-robin arbitration of per-core icache/dcache ports onto one RAM port
module ram_arbiter #(
  parameter int CPUS = 2,
  parameter int WORD_W = 32
) (
  input logic CLK,
  input logic nRST,
  ram_arbiter_if.slave bus
);
  localparam int N = 2 * CPUS;
  localparam int IW = $clog2(N);
  localparam logic [1:0] ACCESS = 2'd2, ERROR = 2'd3;
  typedef enum logic {IDLE, GRANT} state_t;
  state_t state;
  logic [IW-1:0] gnt, rr_ptr, nxt, idx;
  logic [IW:0] s;
  logic [N-1:0] req;
  logic found, greq, done;
  always_comb begin
    req = '0;
    for (int k = 0; k < CPUS; k++) begin
      req[2*k] = bus.dREN[k] | bus.dWEN[k];
      req[2*k+1] = bus.iREN[k];
    end
  end
  // descending scan so the slot closest to rr_ptr is the one kept
  always_comb begin
    nxt = '0;
    found = 1'b0;
    s = '0;
    idx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      s = {1'b0, rr_ptr} + (IW+1)'(i);
      idx = (s >= (IW+1)'(N)) ? IW'(s - (IW+1)'(N)) : IW'(s);
      if (req[idx]) begin
        nxt = idx;
        found = 1'b1;
      end
    end
  end
  assign greq = req[gnt];
  assign done = (state == GRANT) && greq && (bus.ramstate == ACCESS);
  assign bus.busy = (state == GRANT);
  assign bus.gnt_id = gnt;
  always_comb begin
    bus.iwait = '1;
    bus.dwait = '1;
    bus.iload = '0;
    bus.dload = '0;
    bus.ramREN = 1'b0;
    bus.ramWEN = 1'b0;
    bus.ramaddr = '0;
    bus.ramstore = '0;
    for (int k = 0; k < CPUS; k++) begin
      if (state == GRANT && gnt == IW'(2*k)) begin
        bus.ramREN = bus.dREN[k] & ~bus.dWEN[k];
        bus.ramWEN = bus.dWEN[k];
        bus.ramaddr = bus.daddr[k*WORD_W +: WORD_W];
        bus.ramstore = bus.dstore[k*WORD_W +: WORD_W];
        bus.dload[k*WORD_W +: WORD_W] = bus.ramload;
        bus.dwait[k] = ~done;
      end
      if (state == GRANT && gnt == IW'(2*k+1)) begin
        bus.ramREN = bus.iREN[k];
        bus.ramaddr = bus.iaddr[k*WORD_W +: WORD_W];
        bus.iload[k*WORD_W +: WORD_W] = bus.ramload;
        bus.iwait[k] = ~done;
      end
    end
  end
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state <= IDLE;
      gnt <= '0;
      rr_ptr <= '0;
    end else if (state == IDLE) begin
      if (found) begin
        gnt <= nxt;
        state <= GRANT;
      end
    end else if (!greq) begin
      state <= IDLE;
    end else if (bus.ramstate == ACCESS || bus.ramstate == ERROR) begin
      state <= IDLE;
      rr_ptr <= (gnt == IW'(N - 1)) ? '0 : gnt + 1'b1;
    end
  end
endmodule
